// File: rtl/hilo_pkg.sv
// Shared op codes, FSM states and constants for the Hi/Lo multiply/divide unit.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MADD  = 3'd4,
        OP_MADDU = 3'd5,
        OP_MSUB  = 3'd6,
        OP_MSUBU = 3'd7
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_e;

    localparam logic [31:0] DIV0_LO = 32'hFFFFFFFF;

    // Even op codes are the signed variants.
    function automatic logic op_is_signed(input logic [2:0] op);
        return ~op[0];
    endfunction

    function automatic logic op_is_div(input logic [2:0] op);
        return op[2:1] == 2'b01;
    endfunction

endpackage

// File: rtl/hilo_muldiv_datapath.sv
// One iteration of radix-2 shift-add multiply or restoring shift-subtract divide.
module hilo_muldiv_datapath #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    input  logic [WIDTH-1:0] opnd,
    output logic [WIDTH-1:0] hi_next,
    output logic [WIDTH-1:0] lo_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] rem;
    logic             fits;

    always_comb begin
        sum     = {1'b0, hi} + (lo[0] ? {1'b0, opnd} : '0);
        shifted = {hi, lo[WIDTH-1]};
        fits    = shifted >= {1'b0, opnd};
        // When the trial subtraction fits, the remainder is below opnd and fits WIDTH bits.
        rem     = shifted[WIDTH-1:0] - opnd;
        if (is_div) begin
            hi_next = fits ? rem : shifted[WIDTH-1:0];
            lo_next = {lo[WIDTH-2:0], fits};
        end else begin
            hi_next = sum[WIDTH:1];
            lo_next = {sum[0], lo[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/hilo_muldiv_unit.sv
// Iterative multiply/divide engine feeding Hi/Lo write data plus one of WriteEn/Madd/Msub.
module hilo_muldiv_unit
    import hilo_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             Clk,
    input  logic             RstN,
    input  logic             Start,
    input  logic [2:0]       Op,
    input  logic [WIDTH-1:0] OpA,
    input  logic [WIDTH-1:0] OpB,
    input  logic             Cancel,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] WriteHiData,
    output logic [WIDTH-1:0] WriteLoData,
    output logic             WriteEn,
    output logic             Madd,
    output logic             Msub
);

    state_e           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_q;
    logic [WIDTH-1:0] hi, lo, opnd, a_raw;
    logic             neg_lo, neg_hi, div_zero, div_ovf;

    logic [WIDTH-1:0]   hi_next, lo_next;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               in_signed, in_div;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    hilo_muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
        .is_div  (op_is_div(op_q)),
        .hi      (hi),
        .lo      (lo),
        .opnd    (opnd),
        .hi_next (hi_next),
        .lo_next (lo_next)
    );

    always_comb begin
        in_signed = op_is_signed(Op);
        in_div    = op_is_div(Op);
        a_mag     = (in_signed && OpA[WIDTH-1]) ? -OpA : OpA;
        b_mag     = (in_signed && OpB[WIDTH-1]) ? -OpB : OpB;
    end

    // Sign correction and divide special cases, registered on the FIX -> DONE edge.
    always_comb begin
        prod   = neg_lo ? -{hi, lo} : {hi, lo};
        fix_hi = prod[2*WIDTH-1:WIDTH];
        fix_lo = prod[WIDTH-1:0];
        if (op_is_div(op_q)) begin
            if (div_zero) begin
                fix_hi = a_raw;
                fix_lo = DIV0_LO;
            end else if (div_ovf) begin
                fix_hi = '0;
                fix_lo = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                fix_hi = neg_hi ? -hi : hi;
                fix_lo = neg_lo ? -lo : lo;
            end
        end
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state       <= IDLE;
            cnt         <= '0;
            op_q        <= '0;
            hi          <= '0;
            lo          <= '0;
            opnd        <= '0;
            a_raw       <= '0;
            neg_lo      <= 1'b0;
            neg_hi      <= 1'b0;
            div_zero    <= 1'b0;
            div_ovf     <= 1'b0;
            Busy        <= 1'b0;
            Done        <= 1'b0;
            WriteEn     <= 1'b0;
            Madd        <= 1'b0;
            Msub        <= 1'b0;
            WriteHiData <= '0;
            WriteLoData <= '0;
        end else begin
            Done    <= 1'b0;
            WriteEn <= 1'b0;
            Madd    <= 1'b0;
            Msub    <= 1'b0;
            case (state)
                IDLE: begin
                    if (Start && !Cancel) begin
                        op_q     <= Op;
                        hi       <= '0;
                        lo       <= in_div ? a_mag : b_mag;
                        opnd     <= in_div ? b_mag : a_mag;
                        a_raw    <= OpA;
                        neg_lo   <= in_signed && (OpA[WIDTH-1] ^ OpB[WIDTH-1]);
                        neg_hi   <= in_signed && OpA[WIDTH-1];
                        div_zero <= (OpB == '0);
                        div_ovf  <= (Op == OP_DIV) && (OpA == {1'b1, {(WIDTH-1){1'b0}}}) && (OpB == '1);
                        cnt      <= '0;
                        Busy     <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    if (Cancel) begin
                        Busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) state <= FIX;
                    end
                end
                FIX: begin
                    Busy <= 1'b0;
                    if (Cancel) begin
                        state <= IDLE;
                    end else begin
                        WriteHiData <= fix_hi;
                        WriteLoData <= fix_lo;
                        Done        <= 1'b1;
                        WriteEn     <= ~op_q[2];
                        Madd        <= (op_q[2:1] == 2'b10);
                        Msub        <= (op_q[2:1] == 2'b11);
                        state       <= DONE;
                    end
                end
                DONE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Directed and randomized bench for hilo_muldiv_unit against a plain-arithmetic Hi/Lo model.
module tb_hilo_muldiv_unit;
    import hilo_pkg::*;

    logic        Clk = 1'b0;
    logic        RstN = 1'b0;
    logic        Start = 1'b0;
    logic        Cancel = 1'b0;
    logic [2:0]  Op = '0;
    logic [31:0] OpA = '0;
    logic [31:0] OpB = '0;
    logic        Busy, Done, WriteEn, Madd, Msub;
    logic [31:0] WriteHiData, WriteLoData;

    int checks = 0;
    int errors = 0;

    // Behavioural Hi/Lo register file driven by the DUT's write traffic.
    logic        preload = 1'b1;
    logic [63:0] preload_val = '0;
    logic [63:0] file_q;
    logic [63:0] exp_file;

    always #5 Clk = ~Clk;

    hilo_muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (
        .Clk         (Clk),
        .RstN        (RstN),
        .Start       (Start),
        .Op          (Op),
        .OpA         (OpA),
        .OpB         (OpB),
        .Cancel      (Cancel),
        .Busy        (Busy),
        .Done        (Done),
        .WriteHiData (WriteHiData),
        .WriteLoData (WriteLoData),
        .WriteEn     (WriteEn),
        .Madd        (Madd),
        .Msub        (Msub)
    );

    always @(posedge Clk) begin
        if (preload)      file_q <= preload_val;
        else if (WriteEn) file_q <= {WriteHiData, WriteLoData};
        else if (Madd)    file_q <= file_q + {WriteHiData, WriteLoData};
        else if (Msub)    file_q <= file_q - {WriteHiData, WriteLoData};
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected {Hi,Lo} and strobes {WriteEn,Madd,Msub} from plain integer arithmetic.
    function automatic void model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [63:0] res, output logic [2:0] stb);
        longint      sa, sb, q, r;
        logic [63:0] ua, ub;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        stb = (op < 3'd4) ? 3'b100 : (op < 3'd6) ? 3'b010 : 3'b001;
        case (op)
            3'd0, 3'd4, 3'd6: res = sa * sb;
            3'd1, 3'd5, 3'd7: res = ua * ub;
            3'd2: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else begin
                    q   = sa / sb;
                    r   = sa % sb;
                    res = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) res = {a, 32'hFFFFFFFF};
                else        res = {a % b, a / b};
            end
        endcase
    endfunction

    // Called at a negedge; returns at the negedge after the write pulse has dropped.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input bit poke);
        logic [63:0] er;
        logic [2:0]  es;
        int k, busy_cnt, extra;
        model(op, a, b, er, es);
        Start = 1'b1; Op = op; OpA = a; OpB = b;
        @(negedge Clk);
        Start = 1'b0; Op = 3'($urandom); OpA = $urandom; OpB = $urandom;
        k = 1;
        busy_cnt = 0;
        while (!Done && k < 40) begin
            if (Busy) busy_cnt++;
            Start = (poke && k == 5);
            @(negedge Clk);
            k++;
        end
        Start = 1'b0;
        chk("latency", 64'(k), 64'd34);
        chk("busy_cycles", 64'(busy_cnt), 64'd33);
        chk("busy_at_done", {63'd0, Busy}, 64'd0);
        chk("hilo_data", {WriteHiData, WriteLoData}, er);
        chk("strobes", {61'd0, WriteEn, Madd, Msub}, {61'd0, es});
        if (es[2])      exp_file = er;
        else if (es[1]) exp_file = exp_file + er;
        else            exp_file = exp_file - er;
        @(negedge Clk);
        chk("pulse_drop", {60'd0, Done, WriteEn, Madd, Msub}, 64'd0);
        chk("data_held", {WriteHiData, WriteLoData}, er);
        chk("hilo_file", file_q, exp_file);
        if (poke) begin
            extra = 0;
            repeat (40) begin
                @(negedge Clk);
                if (Done) extra++;
            end
            chk("start_while_busy_ignored", 64'(extra), 64'd0);
        end
    endtask

    // Launch a multiply, then kill it with Cancel or RstN after 'at' cycles.
    task automatic abort_op(input bit use_reset, input int at);
        int extra;
        Start = 1'b1; Op = OP_MULTU; OpA = $urandom | 32'h1; OpB = $urandom | 32'h1;
        @(negedge Clk);
        Start = 1'b0;
        repeat (at) @(negedge Clk);
        if (!use_reset) begin
            Cancel = 1'b1;
            @(negedge Clk);
            Cancel = 1'b0;
            chk("cancel_busy", {63'd0, Busy}, 64'd0);
        end else begin
            RstN = 1'b0;
            #1;
            chk("async_reset_ctrl", {59'd0, Busy, Done, WriteEn, Madd, Msub}, 64'd0);
            chk("async_reset_data", {WriteHiData, WriteLoData}, 64'd0);
            @(negedge Clk);
            RstN = 1'b1;
        end
        extra = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Done || WriteEn || Madd || Msub) extra++;
        end
        chk(use_reset ? "no_write_after_reset" : "no_write_after_cancel", 64'(extra), 64'd0);
        chk("file_after_abort", file_q, exp_file);
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] ra, rb;

        repeat (3) @(negedge Clk);
        chk("reset_ctrl", {59'd0, Busy, Done, WriteEn, Madd, Msub}, 64'd0);
        chk("reset_data", {WriteHiData, WriteLoData}, 64'd0);
        RstN = 1'b1;
        preload = 1'b0;
        exp_file = '0;
        @(negedge Clk);

        run_op(OP_MULT, 32'hFFFFFFFD, 32'd7, 1'b0);
        run_op(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        run_op(OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b0);
        run_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        run_op(OP_DIVU, 32'd5, 32'd0, 1'b0);
        run_op(OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        run_op(OP_DIV, 32'hFFFFFFF7, 32'd0, 1'b0);
        run_op(OP_MULT, 32'd0, 32'h12345678, 1'b0);

        preload_val = 64'd100;
        preload = 1'b1;
        @(negedge Clk);
        preload = 1'b0;
        exp_file = 64'd100;
        run_op(OP_MADD, 32'd5, 32'd6, 1'b0);
        chk("madd_file_value", file_q, 64'd130);
        run_op(OP_MSUB, 32'd5, 32'd6, 1'b0);
        run_op(OP_MSUBU, 32'hFFFFFFFF, 32'd2, 1'b0);

        abort_op(1'b0, 10);
        run_op(OP_MULTU, 32'd1234, 32'd5678, 1'b0);

        Start = 1'b1; Cancel = 1'b1; Op = OP_MULT; OpA = 32'd3; OpB = 32'd4;
        @(negedge Clk);
        Start = 1'b0; Cancel = 1'b0;
        chk("start_with_cancel_ignored", {63'd0, Busy}, 64'd0);

        abort_op(1'b1, 20);
        run_op(OP_DIVU, 32'hDEADBEEF, 32'd1000, 1'b1);

        for (int i = 0; i < 12; i++) begin
            rop = 3'($urandom_range(0, 7));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            rb  = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 17)) | (rb & 32'h80000000);
            run_op(rop, ra, rb, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
